// File: rtl/src_pkg.sv
// ---------------------------------------------------------------------------
// src_pkg
//   Shared definitions for the source-buffer path: the packer FSM state
//   type, line/address geometry and a 32-bit byte-swap helper.
//   The source buffer imports the same constants so both ends agree on the
//   line width, address width and per-line word stride.
// ---------------------------------------------------------------------------
package src_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } src_pack_state_t;

    localparam int SRC_LINE_W = 1024;  // one buffer line = 32 words of 32 bits
    localparam int SRC_ADDR_W = 9;     // bit 8 = bank, bits 7:0 = word index
    localparam int SRC_STRIDE = 32;    // word-address step per line
    localparam int SRC_WORD_W = 32;

    // Reverse the byte order of one 32-bit word: {b0,b1,b2,b3}.
    function automatic logic [SRC_WORD_W-1:0] bswap32(input logic [SRC_WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/src_lane_sel.sv
// ---------------------------------------------------------------------------
// src_lane_sel
//   Combinational helper for src_packer.
//   - Decodes the current beat index into a one-hot lane write-enable.
//   - Presents the beat data to be stored in that lane. When the macro
//     SRC_PACKER_BSWAP_EN is defined every 32-bit word of the beat is
//     byte-swapped; otherwise the beat passes through unchanged.
// Ports
//   beat_idx  in   IDX_W   lane index of the beat being accepted
//   data_i    in   IN_W    raw beat data
//   lane_en   out  LANES   one-hot lane select
//   data_o    out  IN_W    data to write into the selected lane
// ---------------------------------------------------------------------------
module src_lane_sel
    import src_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int LANES = 16,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] beat_idx,
    input  logic [IN_W-1:0]  data_i,
    output logic [LANES-1:0] lane_en,
    output logic [IN_W-1:0]  data_o
);

    genvar gi;

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane_dec
            assign lane_en[gi] = (beat_idx == IDX_W'(gi));
        end
    endgenerate

`ifdef SRC_PACKER_BSWAP_EN
    // IN_W is a multiple of 32 in this build; each word is swapped in place.
    generate
        for (gi = 0; gi < IN_W / SRC_WORD_W; gi++) begin : g_bswap
            assign data_o[gi*SRC_WORD_W +: SRC_WORD_W] =
                bswap32(data_i[gi*SRC_WORD_W +: SRC_WORD_W]);
        end
    endgenerate
`else
    assign data_o = data_i;
`endif

endmodule

// File: rtl/src_packer.sv
// ---------------------------------------------------------------------------
// src_packer
//   Packs a narrow valid/ready beat stream into OUT_W-bit lines and writes
//   each finished line into the source buffer with a one-cycle strobe.
//   A start command gives the first line address and the number of lines;
//   the address advances by STRIDE words per line and wraps modulo
//   2^ADDR_W, so consecutive lines run across both banks.
//
//   Optional build macro: SRC_PACKER_BSWAP_EN (byte-swap each 32-bit word
//   of the incoming beat before packing). Timing is identical either way.
//
// Ports
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous reset, active low
//   start       in   1       command pulse, honoured only when idle
//   start_addr  in   ADDR_W  first line address (low bits below STRIDE ignored)
//   line_cnt    in   5       number of lines, 0..16
//   busy        out  1       command in progress
//   done        out  1       one-cycle completion pulse
//   len_err     out  1       with done: s_last arrived before the final line
//   s_valid     in   1       beat valid
//   s_ready     out  1       beat ready (only while filling a line)
//   s_data      in   IN_W    beat data, beat 0 in the lowest bits
//   s_last      in   1       final beat of the transfer
//   src_v       out  1       line write strobe
//   src_a       out  ADDR_W  line word address
//   src_d       out  OUT_W   packed line
// ---------------------------------------------------------------------------
module src_packer
    import src_pkg::*;
#(
    parameter int IN_W   = 64,          // must divide OUT_W
    parameter int OUT_W  = SRC_LINE_W,
    parameter int ADDR_W = SRC_ADDR_W,
    parameter int STRIDE = SRC_STRIDE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [4:0]        line_cnt,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
    input  logic              s_last,
    output logic              src_v,
    output logic [ADDR_W-1:0] src_a,
    output logic [OUT_W-1:0]  src_d
);

    localparam int LANES = OUT_W / IN_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LANES - 1);
    // Clears the word-index bits below one line so the start address is line aligned.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(STRIDE - 1));

    src_pack_state_t   state_q, state_d;
    logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
    logic [4:0]        lines_left_q, lines_left_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OUT_W-1:0]  line_q, line_d;
    logic              last_taken_q, last_taken_d;   // s_last closed the current line
    logic              err_q, err_d;                 // transfer ended short

    logic              s_ready_q, s_ready_d;
    logic              src_v_q, src_v_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d;
    logic [OUT_W-1:0]  src_d_q, src_d_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              len_err_q, len_err_d;

    logic [LANES-1:0]  lane_en;
    logic [IN_W-1:0]   beat_data;
    logic [OUT_W-1:0]  line_w;
    logic              hs;

    // s_ready is a registered decode of FILL, so it is the handshake qualifier.
    assign hs = s_valid & s_ready_q;

    src_lane_sel #(
        .IN_W  (IN_W),
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_lane_sel (
        .beat_idx (beat_idx_q),
        .data_i   (s_data),
        .lane_en  (lane_en),
        .data_o   (beat_data)
    );

    always_comb begin
        // Current line with the accepted beat merged into its lane. Feeding
        // this straight into src_d lets the write happen the cycle after the
        // closing beat without a separate merge cycle.
        line_w = line_q;
        for (int i = 0; i < LANES; i++) begin
            if (hs && lane_en[i]) begin
                line_w[i*IN_W +: IN_W] = beat_data;
            end
        end

        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        lines_left_d = lines_left_q;
        addr_d       = addr_q;
        line_d       = line_q;
        last_taken_d = last_taken_q;
        err_d        = err_q;
        src_a_d      = src_a_q;
        src_d_d      = src_d_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    last_taken_d = 1'b0;
                    err_d        = 1'b0;
                    if (line_cnt != 5'd0) begin
                        state_d      = FILL;
                        addr_d       = start_addr & ADDR_MASK;
                        lines_left_d = line_cnt;
                        beat_idx_d   = '0;
                        line_d       = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            FILL: begin
                line_d = line_w;
                if (hs) begin
                    beat_idx_d = beat_idx_q + IDX_W'(1);
                    if (beat_idx_q == LAST_IDX || s_last) begin
                        state_d      = WRITE;
                        src_a_d      = addr_q;
                        src_d_d      = line_w;
                        last_taken_d = s_last;
                        // Only a last beat that exactly completes the final line is a clean end.
                        err_d        = s_last &&
                                       !(lines_left_q == 5'd1 && beat_idx_q == LAST_IDX);
                    end
                end
            end

            WRITE: begin
                addr_d       = addr_q + ADDR_W'(STRIDE);
                lines_left_d = lines_left_q - 5'd1;
                // The line has been captured in src_d; clear it so unwritten
                // lanes of the next line read as zero.
                line_d       = '0;
                beat_idx_d   = '0;
                state_d      = (lines_left_q == 5'd1 || last_taken_q) ? DONE : FILL;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered decodes of the next state.
        s_ready_d = (state_d == FILL);
        src_v_d   = (state_d == WRITE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        len_err_d = (state_d == DONE) && err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_idx_q   <= '0;
            lines_left_q <= '0;
            addr_q       <= '0;
            line_q       <= '0;
            last_taken_q <= 1'b0;
            err_q        <= 1'b0;
            s_ready_q    <= 1'b0;
            src_v_q      <= 1'b0;
            src_a_q      <= '0;
            src_d_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            lines_left_q <= lines_left_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            last_taken_q <= last_taken_d;
            err_q        <= err_d;
            s_ready_q    <= s_ready_d;
            src_v_q      <= src_v_d;
            src_a_q      <= src_a_d;
            src_d_q      <= src_d_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            len_err_q    <= len_err_d;
        end
    end

    assign s_ready = s_ready_q;
    assign src_v   = src_v_q;
    assign src_a   = src_a_q;
    assign src_d   = src_d_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign len_err = len_err_q;

endmodule

// File: tb/tb_src_packer.sv
// ---------------------------------------------------------------------------
// tb_src_packer
//   Directed bench for src_packer. Each command pushes its expected line
//   writes and completion into queues; a monitor on the falling edge pops
//   and compares whenever the DUT strobes src_v or done.
// ---------------------------------------------------------------------------
module tb_src_packer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [8:0]    start_addr;
    logic [4:0]    line_cnt;
    logic          busy;
    logic          done;
    logic          len_err;
    logic          s_valid;
    logic          s_ready;
    logic [63:0]   s_data;
    logic          s_last;
    logic          src_v;
    logic [8:0]    src_a;
    logic [1023:0] src_d;

    always #5 clk = ~clk;

    src_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .line_cnt   (line_cnt),
        .busy       (busy),
        .done       (done),
        .len_err    (len_err),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .src_v      (src_v),
        .src_a      (src_a),
        .src_d      (src_d)
    );

    typedef struct {
        logic [8:0]    a;
        logic [1023:0] d;
    } wr_t;

    typedef struct {
        logic err;
        bit   had_wr;
    } dn_t;

    wr_t  wq[$];
    dn_t  dq[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_src_v = 1'b0;
    wr_t  mon_w;
    dn_t  mon_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int l = 0; l < 16; l++) begin
            if (bad < 0 && act[l*64 +: 64] !== exp[l*64 +: 64]) bad = l;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s lane %0d got %h expected %h", name, bad,
                     act[bad*64 +: 64], exp[bad*64 +: 64]);
        end
    endtask

    // Beat pattern: tag and index are visible in every beat.
    function automatic logic [63:0] beat_val(input int tag, input int i);
        if (tag == 0 && i == 0) return 64'h11223344_55667788;
        return {8'(tag), 8'(i), 16'hC0DE, 16'(i * 7 + tag), 16'(~i)};
    endfunction

    function automatic logic [63:0] tb_swap(input logic [63:0] x);
        logic [63:0] y;
        y = x;
`ifdef SRC_PACKER_BSWAP_EN
        for (int w = 0; w < 2; w++)
            for (int b = 0; b < 4; b++)
                y[w*32 + b*8 +: 8] = x[w*32 + (3 - b)*8 +: 8];
`endif
        return y;
    endfunction

    // Expected writes/completion for one command of nbeats beats.
    task automatic model(input logic [8:0] addr, input int cnt, input int tag,
                         input int nbeats, input bit has_last);
        logic [8:0]    a;
        logic [1023:0] line;
        int rem, k, nb, nlines;
        bit err;
        a = addr & 9'h1E0;
        rem = nbeats; k = 0; nlines = 0; err = 1'b0;
        for (int l = 0; l < cnt; l++) begin
            if (rem == 0) break;
            nb = (rem < 16) ? rem : 16;
            line = '0;
            for (int j = 0; j < nb; j++) begin
                line[j*64 +: 64] = tb_swap(beat_val(tag, k));
                k++;
            end
            wq.push_back('{a, line});
            a = a + 9'd32;
            rem -= nb;
            nlines++;
            if (has_last && rem == 0) begin
                err = (l < cnt - 1) || (nb < 16);
                break;
            end
        end
        dq.push_back('{err, nlines > 0});
    endtask

    task automatic start_cmd(input logic [8:0] addr, input logic [4:0] cnt);
        @(negedge clk);
        start = 1'b1; start_addr = addr; line_cnt = cnt;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic send_beats(input int tag, input int n, input bit has_last, input bit throttle);
        int i, budget;
        i = 0; budget = 0;
        while (i < n) begin
            @(negedge clk);
            budget++;
            if (budget > 2000) begin
                checks++; errors++;
                $display("FAIL beat_timeout beat %0d of %0d, required all accepted", i, n);
                break;
            end
            s_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = beat_val(tag, i);
            s_last  = has_last && (i == n - 1);
            if (s_valid && s_ready) i++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        // One cycle after the closing handshake the line must be written.
        if (n > 0 && (has_last || (n % 16) == 0))
            chk("src_v_latency", 64'(src_v), 64'd1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((wq.size() != 0 || dq.size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("queues_drained", 64'(wq.size() + dq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (src_v) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_src_v got a=%h expected no write", src_a);
                end else begin
                    mon_w = wq.pop_front();
                    chk("src_a", 64'(src_a), 64'(mon_w.a));
                    chk_line("src_d", src_d, mon_w.d);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done got 1 expected 0");
                end else begin
                    mon_d = dq.pop_front();
                    chk("len_err", 64'(len_err), 64'(mon_d.err));
                    chk("done_after_last_write", 64'(prev_src_v), 64'(mon_d.had_wr));
                end
            end else if (len_err) begin
                checks++; errors++;
                $display("FAIL len_err_without_done got 1 expected 0");
            end
        end
        prev_src_v = src_v;
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; line_cnt = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_src_v", 64'(src_v), 64'd0);
        chk("rst_src_a", 64'(src_a), 64'd0);
        chk_line("rst_src_d", src_d, '0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_s_ready", 64'(s_ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Two full lines, s_valid held high: writes at 0x000, 0x020
        model(9'h000, 2, 1, 32, 1'b1);
        start_cmd(9'h000, 5'd2);
        send_beats(1, 32, 1'b1, 1'b0);
        wait_idle();

        // Bank crossing: 0x0E0, 0x100, 0x120
        model(9'h0E0, 3, 2, 48, 1'b1);
        start_cmd(9'h0E0, 5'd3);
        send_beats(2, 48, 1'b1, 1'b0);
        wait_idle();

        // Address wrap: 0x1E0, 0x000
        model(9'h1E0, 2, 3, 32, 1'b1);
        start_cmd(9'h1E0, 5'd2);
        send_beats(3, 32, 1'b1, 1'b0);
        wait_idle();

        // Early last on beat 5, unaligned start 0x04B -> one write at 0x040, lanes 6..15 zero
        model(9'h04B, 2, 4, 6, 1'b1);
        start_cmd(9'h04B, 5'd2);
        send_beats(4, 6, 1'b1, 1'b0);
        wait_idle();

        // s_last at end of first of two lines: one write, len_err
        model(9'h0A0, 2, 5, 16, 1'b1);
        start_cmd(9'h0A0, 5'd2);
        send_beats(5, 16, 1'b1, 1'b0);
        wait_idle();

        // Final line completes without s_last: normal end
        model(9'h160, 1, 6, 16, 1'b0);
        start_cmd(9'h160, 5'd1);
        send_beats(6, 16, 1'b0, 1'b0);
        wait_idle();

        // line_cnt = 0: done only
        model(9'h100, 0, 7, 0, 1'b1);
        start_cmd(9'h100, 5'd0);
        wait_idle();

        // Throttled s_valid, second start while busy must be ignored
        model(9'h020, 2, 8, 32, 1'b1);
        start_cmd(9'h020, 5'd2);
        fork
            send_beats(8, 32, 1'b1, 1'b1);
            begin
                repeat (8) @(negedge clk);
                start = 1'b1; start_addr = 9'h1C0; line_cnt = 5'd3;
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_idle();
        chk("busy_after_done", 64'(busy), 64'd0);

        // Byte-order vector: beat 0 = 0x11223344_55667788
        model(9'h180, 1, 0, 16, 1'b1);
        start_cmd(9'h180, 5'd1);
        send_beats(0, 16, 1'b1, 1'b0);
        wait_idle();

        // Reset mid-line: partial line abandoned, nothing written, no done
        start_cmd(9'h000, 5'd1);
        send_beats(9, 5, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_src_v", 64'(src_v), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_s_ready", 64'(s_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_queues", 64'(wq.size() + dq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
